// File: rtl/tile_prefetch_buffer.sv
// tile_prefetch_buffer: fills one TILE_H-row band of the zero-padded feature map
// from memory into a ping-pong column buffer, then serves column reads from the
// committed (front) bank while the next band is fetched into the back bank.
module tile_prefetch_buffer #(
   parameter  int unsigned OUT_W    = 112,
   parameter  int unsigned OUT_H    = 112,
   parameter  int unsigned TILE_H   = 6,
   parameter  int unsigned PADDING  = 1,
   parameter  int unsigned DATA_W   = 8,
   localparam int unsigned PADDED_W = OUT_W + 2 * PADDING,
   localparam int unsigned TR_W     = $clog2(OUT_H),
   localparam int unsigned RA_W     = $clog2(PADDED_W),
   localparam int unsigned MA_W     = $clog2(OUT_W * OUT_H),
   localparam int unsigned COL_W    = TILE_H * DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prefetch_start,
   input  logic [TR_W-1:0]   prefetch_tile_row,
   output logic              prefetch_done,
   output logic              prefetch_busy,
   output logic              buffer_ready,
   input  logic              read_enable,
   input  logic [RA_W-1:0]   read_addr,
   output logic [COL_W-1:0]  read_data,
   output logic              read_valid,
   output logic              mem_rd_en,
   output logic [MA_W-1:0]   mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data
);

   // Row/column arithmetic is wide enough that tile_row + r never wraps.
   localparam int unsigned PR_SPEC = $clog2(OUT_H + 2 * PADDING + TILE_H);
   localparam int unsigned PR_W    = (PR_SPEC > TR_W) ? PR_SPEC : TR_W + 1;
   localparam int unsigned RW      = (TILE_H > 1) ? $clog2(TILE_H) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_COMMIT
   } state_t;

   state_t              state_q;
   logic [RA_W-1:0]     col_q;
   logic [RW-1:0]       row_q;
   logic [TR_W-1:0]     tile_row_q;
   logic [COL_W-1:0]    col_buf_q;
   logic                mem_wait_q;
   logic                mem_drop_q;
   logic                front_q;

   logic [COL_W-1:0]    bank_q [2][PADDED_W];

   logic [PR_W-1:0]     pr_c;
   logic [PR_W-1:0]     c_c;
   logic                elem_pad_c;
   logic                elem_done_c;
   logic                col_last_row_c;
   logic                bank_we_c;
   logic [DATA_W-1:0]   elem_val_c;
   logic [COL_W-1:0]    col_word_c;
   logic [MA_W-1:0]     addr_c;

   // Current element classification, memory address and assembled column word.
   always_comb begin
      pr_c           = PR_W'(tile_row_q) + PR_W'(row_q);
      c_c            = PR_W'(col_q);
      elem_pad_c     = (pr_c < PR_W'(PADDING)) || (pr_c >= PR_W'(OUT_H + PADDING)) ||
                       (c_c < PR_W'(PADDING)) || (c_c >= PR_W'(OUT_W + PADDING));
      addr_c         = MA_W'(pr_c - PR_W'(PADDING)) * MA_W'(OUT_W) +
                       MA_W'(c_c - PR_W'(PADDING));
      elem_val_c     = elem_pad_c ? '0 : mem_rd_data;
      elem_done_c    = (state_q == ST_FILL) && !prefetch_start && !mem_drop_q &&
                       (elem_pad_c || (mem_wait_q && mem_rd_valid));
      col_last_row_c = (row_q == RW'(TILE_H - 1));
      bank_we_c      = elem_done_c && col_last_row_c;
      col_word_c     = col_buf_q;
      col_word_c[32'(row_q) * DATA_W +: DATA_W] = elem_val_c;
   end

   // Back-bank column write in the cycle the column's last row resolves.
   always_ff @(posedge clk) begin
      if (bank_we_c) begin
         bank_q[~front_q][col_q] <= col_word_c;
      end
   end

   // Fill sequencer: IDLE -> FILL -> COMMIT, memory handshake and bank swap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         row_q         <= '0;
         tile_row_q    <= '0;
         col_buf_q     <= '0;
         mem_wait_q    <= 1'b0;
         mem_drop_q    <= 1'b0;
         front_q       <= 1'b0;
         prefetch_done <= 1'b0;
         prefetch_busy <= 1'b0;
         buffer_ready  <= 1'b0;
         mem_rd_en     <= 1'b0;
         mem_rd_addr   <= '0;
      end else begin
         prefetch_done <= 1'b0;
         mem_rd_en     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (prefetch_start) begin
                  state_q       <= ST_FILL;
                  col_q         <= '0;
                  row_q         <= '0;
                  tile_row_q    <= prefetch_tile_row;
                  prefetch_busy <= 1'b1;
               end
            end
            ST_FILL: begin
               if (prefetch_start) begin
                  // Abort and restart; an in-flight response must be swallowed.
                  col_q      <= '0;
                  row_q      <= '0;
                  tile_row_q <= prefetch_tile_row;
                  mem_wait_q <= mem_wait_q && !mem_rd_valid;
                  mem_drop_q <= mem_wait_q && !mem_rd_valid;
               end else if (mem_drop_q) begin
                  if (mem_rd_valid) begin
                     mem_wait_q <= 1'b0;
                     mem_drop_q <= 1'b0;
                  end
               end else if (elem_done_c) begin
                  mem_wait_q <= 1'b0;
                  col_buf_q  <= col_word_c;
                  if (col_last_row_c) begin
                     row_q <= '0;
                     if (col_q == RA_W'(PADDED_W - 1)) begin
                        state_q       <= ST_COMMIT;
                        prefetch_done <= 1'b1;
                     end else begin
                        col_q <= col_q + RA_W'(1);
                     end
                  end else begin
                     row_q <= row_q + RW'(1);
                  end
               end else if (!mem_wait_q) begin
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= addr_c;
                  mem_wait_q  <= 1'b1;
               end
            end
            ST_COMMIT: begin
               front_q      <= ~front_q;
               buffer_ready <= 1'b1;
               if (prefetch_start) begin
                  state_q       <= ST_FILL;
                  col_q         <= '0;
                  row_q         <= '0;
                  tile_row_q    <= prefetch_tile_row;
                  prefetch_busy <= 1'b1;
               end else begin
                  state_q       <= ST_IDLE;
                  prefetch_busy <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Column read port: registered lookup into the front bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_valid <= 1'b0;
         read_data  <= '0;
      end else begin
         read_valid <= read_enable && buffer_ready;
         if (read_enable && buffer_ready && (read_addr < RA_W'(PADDED_W))) begin
            read_data <= bank_q[front_q][read_addr];
         end else begin
            read_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tile_prefetch_buffer.sv
// Testbench for tile_prefetch_buffer: randomized fills and reads checked by a
// scoreboard against a padded-image reference model.
module tb_tile_prefetch_buffer;

   localparam int unsigned OUT_W    = 112;
   localparam int unsigned OUT_H    = 112;
   localparam int unsigned TILE_H   = 6;
   localparam int unsigned PADDING  = 1;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned PADDED_W = OUT_W + 2 * PADDING;
   localparam int unsigned TR_W     = $clog2(OUT_H);
   localparam int unsigned RA_W     = $clog2(PADDED_W);
   localparam int unsigned MA_W     = $clog2(OUT_W * OUT_H);
   localparam int unsigned COL_W    = TILE_H * DATA_W;

   logic              clk;
   logic              rst_n;
   logic              prefetch_start;
   logic [TR_W-1:0]   prefetch_tile_row;
   logic              prefetch_done;
   logic              prefetch_busy;
   logic              buffer_ready;
   logic              read_enable;
   logic [RA_W-1:0]   read_addr;
   logic [COL_W-1:0]  read_data;
   logic              read_valid;
   logic              mem_rd_en;
   logic [MA_W-1:0]   mem_rd_addr;
   logic              mem_rd_valid;
   logic [DATA_W-1:0] mem_rd_data;

   tile_prefetch_buffer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .prefetch_start    (prefetch_start),
      .prefetch_tile_row (prefetch_tile_row),
      .prefetch_done     (prefetch_done),
      .prefetch_busy     (prefetch_busy),
      .buffer_ready      (buffer_ready),
      .read_enable       (read_enable),
      .read_addr         (read_addr),
      .read_data         (read_data),
      .read_valid        (read_valid),
      .mem_rd_en         (mem_rd_en),
      .mem_rd_addr       (mem_rd_addr),
      .mem_rd_valid      (mem_rd_valid),
      .mem_rd_data       (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int  model_front   = 0;
   int  model_pending = 0;
   bit  model_ready   = 1'b0;
   int  done_cnt      = 0;
   int  req_cnt       = 0;
   int  max_addr      = 0;
   int  rst_cnt       = 0;
   int  lat_max       = 1;
   bit  mem_out       = 1'b0;
   bit  bg_en         = 1'b0;
   bit  bg_owned      = 1'b0;
   logic [COL_W-1:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // golden padded image: pixel(row,col) = (row*7+col)&0xFF, zero outside the image
   function automatic logic [COL_W-1:0] gold_col(input int tr, input int c);
      logic [COL_W-1:0] v;
      v = '0;
      for (int r = 0; r < int'(TILE_H); r++) begin
         int pr;
         pr = tr + r;
         if (pr >= int'(PADDING) && pr < int'(OUT_H + PADDING) &&
             c >= int'(PADDING) && c < int'(OUT_W + PADDING))
            v[r*DATA_W +: DATA_W] = DATA_W'(((pr - int'(PADDING)) * 7 + (c - int'(PADDING))) & 255);
      end
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] pixel(input int a);
      return DATA_W'(((a / int'(OUT_W)) * 7 + (a % int'(OUT_W))) & 255);
   endfunction

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic rd_push(input int a, input bit use_k, input logic [COL_W-1:0] k);
      read_enable = 1'b1;
      read_addr   = RA_W'(a);
      if (model_ready) exp_q.push_back(use_k ? k : gold_col(model_front, a));
   endtask

   task automatic rd(input int a, input bit use_k, input logic [COL_W-1:0] k);
      rd_push(a, use_k, k);
      tick();
      read_enable = 1'b0;
   endtask

   task automatic sweep();
      for (int c = 0; c < int'(PADDED_W); c++) rd(c, 1'b0, '0);
      repeat (3) tick();
   endtask

   task automatic start(input int tr);
      prefetch_tile_row = TR_W'(tr);
      prefetch_start    = 1'b1;
      model_pending     = tr;
      tick();
      prefetch_start    = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string name);
      int target;
      int n;
      target = done_cnt + 1;
      n = 0;
      while (done_cnt < target && n < maxc) begin
         tick();
         n++;
      end
      check(name, 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_done"},   64'(prefetch_done), 64'd0);
      check({tag, "_busy"},   64'(prefetch_busy), 64'd0);
      check({tag, "_ready"},  64'(buffer_ready),  64'd0);
      check({tag, "_rvalid"}, 64'(read_valid),    64'd0);
      check({tag, "_rdata"},  64'(read_data),     64'd0);
      check({tag, "_men"},    64'(mem_rd_en),     64'd0);
      check({tag, "_maddr"},  64'(mem_rd_addr),   64'd0);
   endtask

   // memory responder: one request at a time, random latency 1..lat_max
   initial begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mem_rd_en) begin
            int a;
            int ep;
            int lat;
            a  = int'(mem_rd_addr);
            ep = rst_cnt;
            req_cnt++;
            if (a > max_addr) max_addr = a;
            check("mem_addr_range", 64'(a < int'(OUT_W * OUT_H)), 64'd1);
            lat = $urandom_range(lat_max, 1);
            mem_out = 1'b1;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               if (ep == rst_cnt) begin
                  check("mem_second_request", 64'(mem_rd_en), 64'd0);
                  check("mem_addr_hold", 64'(mem_rd_addr), 64'(a));
               end
            end
            mem_rd_valid = 1'b1;
            mem_rd_data  = pixel(a);
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_out      = 1'b0;
         end
      end
   end

   // commit tracking: front model switches at the edge ending the done cycle
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (prefetch_done === 1'b1) begin
            done_cnt++;
            @(posedge clk);
            #1;
            model_front = model_pending;
            model_ready = 1'b1;
         end
      end
   end

   // monitor: pops the scoreboard whenever the DUT presents a column
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_unexpected actual=valid data=%0h expected=no read", read_data);
            end else begin
               check("read_col", 64'(read_data), 64'(exp_q.pop_front()));
            end
         end
         check("buffer_ready", 64'(buffer_ready), 64'(model_ready));
      end
   end

   // background random reader (addresses include out-of-range columns)
   initial begin
      forever begin
         tick();
         if (bg_owned) begin
            read_enable = 1'b0;
            bg_owned    = 1'b0;
         end
         if (bg_en && $urandom_range(1, 0) == 1) begin
            rd_push($urandom_range(127, 0), 1'b0, '0);
            bg_owned = 1'b1;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int d0;
      rst_n             = 1'b0;
      prefetch_start    = 1'b0;
      prefetch_tile_row = '0;
      read_enable       = 1'b0;
      read_addr         = '0;
      repeat (3) tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      tick();

      // 1: first tile, latency 1
      lat_max = 1;
      base = req_cnt;
      d0   = done_cnt;
      start(0);
      check("t1_busy", 64'(prefetch_busy), 64'd1);
      wait_done(8000, "t1_done_timeout");
      tick();
      check("t1_busy_clear", 64'(prefetch_busy), 64'd0);
      check("t1_requests", 64'(req_cnt - base), 64'd560);
      repeat (5) tick();
      check("t1_done_count", 64'(done_cnt - d0), 64'd1);
      rd(0, 1'b1, '0);
      rd(113, 1'b1, '0);
      rd(1, 1'b1, 48'h1C150E070000);
      repeat (3) tick();

      // 2: last tile
      max_addr = 0;
      base = req_cnt;
      d0   = done_cnt;
      start(108);
      wait_done(8000, "t2_done_timeout");
      repeat (5) tick();
      check("t2_requests", 64'(req_cnt - base), 64'd560);
      check("t2_max_addr", 64'(max_addr), 64'd12543);
      check("t2_done_count", 64'(done_cnt - d0), 64'd1);
      sweep();

      // 3: reads during a fill return the previous tile
      start(0);
      wait_done(8000, "t3a_done_timeout");
      tick();
      d0 = done_cnt;
      start(4);
      rd(5, 1'b0, '0);
      repeat (50) tick();
      rd(5, 1'b0, '0);
      rd(5, 1'b1, gold_col(0, 5));
      wait_done(8000, "t3b_done_timeout");
      tick();
      rd(5, 1'b0, '0);
      rd(5, 1'b1, gold_col(4, 5));
      repeat (3) tick();
      check("t3_done_count", 64'(done_cnt - d0), 64'd1);

      // 4: abort with a request outstanding, random latency
      lat_max = 8;
      for (int it = 0; it < 2; it++) begin
         int tra;
         int trb;
         int n;
         tra = $urandom_range(108, 0);
         trb = (tra + 1 + $urandom_range(50, 0)) % 109;
         d0  = done_cnt;
         start(tra);
         repeat ($urandom_range(300, 20)) tick();
         n = 0;
         while (!(mem_out && !mem_rd_valid) && n < 5000) begin
            tick();
            n++;
         end
         check("t4_abort_window", 64'(n < 5000), 64'd1);
         start(trb);
         wait_done(30000, "t4_done_timeout");
         repeat (20) tick();
         check("t4_done_count", 64'(done_cnt - d0), 64'd1);
         sweep();
      end

      // 5: reset in the middle of a fill
      lat_max = 4;
      start(20);
      repeat (50) tick();
      rst_n       = 1'b0;
      model_ready = 1'b0;
      rst_cnt++;
      tick();
      check_outputs_zero("midreset");
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         rd(7 + i, 1'b0, '0);
         check("t5_no_valid", 64'(read_valid), 64'd0);
      end
      repeat (20) tick();

      // 6: scanner loopback over the whole image with background reads
      lat_max = 1;
      d0 = done_cnt;
      bg_en = 1'b1;
      for (int t = 0; t < 28; t++) begin
         start(4 * t);
         wait_done(8000, "t6_done_timeout");
         tick();
      end
      bg_en = 1'b0;
      repeat (3) tick();
      read_enable = 1'b0;
      repeat (3) tick();
      check("t6_done_count", 64'(done_cnt - d0), 64'd28);
      sweep();

      repeat (5) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
